// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 codes,
// FSM state encoding and the wait-counter width.
package data_mem_resp_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_mem_resp_load_align.sv
// Load lane selection and sign/zero extension for a 32-bit memory word.
module load_align
    import data_mem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  f3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase

        // Halfword lane ignores addr_lo[0]; misaligned halves align down.
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        result = 32'h0;
        case (f3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            F3_W:    result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Wait-state data memory responder with valid/ready request and response.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [31:0]        rword_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               access;
    logic               f3_bad;
    logic               range_bad;
    logic               misalign_bad;
    logic               fault;
    logic               do_write;
    logic [3:0]         be;
    logic [31:0]        wlane;
    logic [AW-1:0]      widx;
    logic [31:0]        aligned;

    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    assign widx     = addr_q[AW+1:2];
    assign fault    = f3_bad || range_bad || misalign_bad;
    assign do_write = access && we_q && !fault;

    always_comb begin
        if (we_q) begin
            f3_bad = (f3_q > F3_W);
        end else begin
            f3_bad = !((f3_q == F3_B) || (f3_q == F3_H) || (f3_q == F3_W) ||
                       (f3_q == F3_BU) || (f3_q == F3_HU));
        end
        range_bad = (addr_q[31:2] >= 30'(DEPTH_WORDS));
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        case (f3_q)
            F3_H, F3_HU: misalign_bad = addr_q[0];
            F3_W:        misalign_bad = (addr_q[1:0] != 2'b00);
            default:     misalign_bad = 1'b0;
        endcase
`else
        misalign_bad = 1'b0;
`endif
    end

    // Store lane replication and byte enables; misaligned H/W align down.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        case (f3_q)
            F3_B: begin
                wlane = {4{wdata_q[7:0]}};
                be    = 4'b0001 << addr_q[1:0];
            end
            F3_H: begin
                wlane = {2{wdata_q[15:0]}};
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                wlane = wdata_q;
                be    = 4'b1111;
            end
            default: begin
                wlane = wdata_q;
                be    = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_f3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    err_d   = fault;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Storage and its registered read port carry no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
        if (access) begin
            rword_q <= mem[widx];
        end
    end

    load_align u_load_align (
        .word    (rword_q),
        .addr_lo (addr_q[1:0]),
        .f3      (f3_q),
        .result  (aligned)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? aligned : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed, table-driven bench for data_mem_resp (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_data_mem_resp;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int EXP_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int passed;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_f3    (req_f3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request and leaves the DUT in RESP with rsp_ready low.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic finishResp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] held;

        checks = 0;
        passed = 0;

        addVec(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        addVec(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        addVec(0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
        addVec(0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
        addVec(0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
        addVec(0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0);
        addVec(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 0);
        addVec(1, 3'b000, 32'h11, 32'h00000055, 32'h0, 0);
        addVec(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0);
        addVec(1, 3'b001, 32'h12, 32'h1234A5A5, 32'h0, 0);
        addVec(0, 3'b010, 32'h10, 32'h0, 32'hA5A555EF, 0);
        addVec(1, 3'b010, 32'h00, 32'h11223344, 32'h0, 0);
        addVec(0, 3'b010, 32'h02, 32'h0, TRAP ? 32'h0 : 32'h11223344, TRAP);
        addVec(0, 3'b011, 32'h00, 32'h0, 32'h0, 1);
        addVec(1, 3'b011, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
        addVec(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1);
        addVec(0, 3'b010, 32'h400, 32'h0, 32'h0, 1);
        addVec(0, 3'b010, 32'h00, 32'h0, 32'h11223344, 0);
        addVec(0, 3'b100, 32'h01, 32'h0, 32'h00000033, 0);
        addVec(0, 3'b001, 32'h01, 32'h0, TRAP ? 32'h0 : 32'h00003344, TRAP);
        addVec(1, 3'b010, 32'h20, 32'h00000000, 32'h0, 0);

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_f3    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset req_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(EXP_LAT));
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            finishResp();
        end

        // Backpressure: response held for five cycles, competing request ignored.
        applyStimulus(0, 3'b010, 32'h10, 32'h0, held, er, lat);
        checkOutput("hold first rdata", held, 32'hA5A555EF);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_f3    = 3'b010;
        req_addr  = 32'h10;
        req_wdata = 32'h0BADBAD0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d rsp_valid", c), 32'(rsp_valid), 32'h1);
            checkOutput($sformatf("hold%0d rdata", c), rsp_rdata, held);
            checkOutput($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("release rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("release req_ready", 32'(req_ready), 32'h1);
        applyStimulus(0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checkOutput("no stray store", rd, 32'hA5A555EF);
        finishResp();

        // Reset during WAIT discards the pending store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_f3    = 3'b010;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("wait-reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("wait-reset rdata", rsp_rdata, 32'h0);
        checkOutput("wait-reset err", 32'(rsp_err), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("wait-reset req_ready", 32'(req_ready), 32'h1);
        applyStimulus(0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checkOutput("discarded store", rd, 32'h0);
        finishResp();
        applyStimulus(0, 3'b010, 32'h00, 32'h0, rd, er, lat);
        checkOutput("persist across reset", rd, 32'h11223344);
        finishResp();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 256, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, 2, wait states between request accept and memory access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_f3  input  3  RV32I funct3 size/sign code.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request faulted.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 SHALL latch we/f3/addr/wdata on req_valid && req_ready and load the wait counter with WAIT_CYCLES.
REQ-017 WAIT SHALL decrement the counter each cycle and perform the access in the cycle the counter is 0; with WAIT_CYCLES = 0 the access happens in the first WAIT cycle.
REQ-018 Accept at edge T SHALL give rsp_valid high after edge T+WAIT_CYCLES+1.
REQ-019 RESP SHALL hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready = 1, then return to IDLE on that edge; no new request is accepted in the same cycle.
REQ-020 Loads: f3 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW full word; byte lane = addr[1:0], half lane = addr[1].
REQ-021 Stores: f3 000 SB, 001 SH, 010 SW write only the addressed lanes; other lanes keep their value.
REQ-022 Illegal f3 (load 011/110/111, store >= 011) SHALL set rsp_err = 1, perform no write, rsp_rdata = 0.
REQ-023 Word index addr[31:2] >= DEPTH_WORDS SHALL set rsp_err = 1, perform no write, rsp_rdata = 0.
REQ-024 Storage SHALL be synchronous; contents not reset (undefined until written).

Reset
REQ-025 rst_n low SHALL force state IDLE, counter 0, req_ready = 1 after release, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-026 Reset asserted in WAIT before the access cycle SHALL discard the request with no write; a write completed before reset SHALL persist.

Configuration
REQ-027 Macro DATA_MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0] = 1 or LW/SW with addr[1:0] != 0 SHALL give rsp_err = 1, no write, rsp_rdata = 0.
REQ-028 Macro undefined: misaligned accesses SHALL silently align down (halfword: clear addr[0]; word: clear addr[1:0]); rsp_err from alignment never asserted.

Structure
REQ-029 Shared package SHALL hold the funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, and 4-bit counter width constant.
REQ-030 Load lane selection and extension SHALL live in sub-module load_align (combinational: word, addr[1:0], f3 -> 32-bit result).

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, each rsp_valid 3 cycles after accept (WAIT_CYCLES=2).
REQ-032 After REQ-031 data, LB @0x10 -> 0xFFFFFFEF; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
REQ-033 SB 0x55 @0x11 over 0xDEADBEEF, LW @0x10 -> 0xDEAD55EF.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0 throughout; released -> IDLE next edge.
REQ-035 LW @0x2 with macro -> rsp_err 1, rdata 0; without macro -> returns word @0x0; SW @ DEPTH_WORDS*4 -> rsp_err 1, memory unchanged.
REQ-036 rst_n pulsed low during WAIT of SW 0x12345678 @0x20 -> outputs at reset values, later LW @0x20 does not return 0x12345678 (word pre-written 0 stays 0).
